onchip_mem_stream_reader: RTL and testbench

- Read-side streaming engine sitting directly downstream of the on-chip RAM's second slave port (s2).
- Accepts a command of start word address and word count, and issues back-to-back reads on s2.
- Absorbs the RAM's fixed 1-cycle read latency in a small FIFO.
- Presents the words on an Avalon-ST source with backpressure, sop/eop framing and a done pulse, so accelerators or peripherals can consume RAM contents at 1 word/clock.

---
 rtl/onchip_mem_stream_reader.sv | 155 +++++++++++++++
 tb/tb_onchip_mem_stream_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_reader
// Description : Streams a word range out of the RAM s2 port onto Avalon-ST.
// Revision    : 1.0
// ============================================================================
module onchip_mem_stream_reader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [3:0]            mem_byteenable,
   output logic                  mem_clken,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   output logic                  src_valid,
   input  logic                  src_ready,
   output logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_sop,
   output logic                  src_eop,
   output logic                  busy,
   output logic                  done
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [c_PTR_W+1:0] c_DEPTH = (c_PTR_W+2)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr_ctr;
   logic [LEN_WIDTH-1:0]    r_issue_left;
   logic [LEN_WIDTH-1:0]    r_beat_left;
   logic                    r_inflight;
   logic                    r_first;
   logic                    r_zero_done;
   logic [DATA_WIDTH-1:0]   r_fifo [FIFO_DEPTH];
   logic [c_PTR_W-1:0]      r_wr_ptr;
   logic [c_PTR_W-1:0]      r_rd_ptr;
   logic [c_PTR_W:0]        r_count;

   logic                    w_accept;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_issue;
   logic                    w_last_pop;
   logic [c_PTR_W+1:0]      w_occ;

   assign cmd_ready  = (r_state == ST_IDLE) && !reset;
   assign w_accept   = cmd_valid && cmd_ready;
   assign src_valid  = (r_count != '0);
   assign w_pop      = src_valid && src_ready;
   assign w_push     = r_inflight;

   // Credit covers buffered words plus the read still in flight; a same-cycle pop frees one slot.
   assign w_occ      = {1'b0, r_count} + {{(c_PTR_W+1){1'b0}}, r_inflight};
   assign w_issue    = !reset && (r_state == ST_RUN) && (r_issue_left != '0) &&
                       ((w_occ < c_DEPTH) || (w_pop && (w_occ == c_DEPTH)));
   assign w_last_pop = !reset && (r_state == ST_DRAIN) && w_pop &&
                       (r_beat_left == LEN_WIDTH'(1));

   assign mem_address    = r_addr_ctr;
   assign mem_chipselect = w_issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   assign src_data = r_fifo[r_rd_ptr];
   assign src_sop  = src_valid && r_first;
   assign src_eop  = src_valid && (r_beat_left == LEN_WIDTH'(1));
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_zero_done || w_last_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= mem_readdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_addr_ctr   <= '0;
         r_issue_left <= '0;
         r_beat_left  <= '0;
         r_inflight   <= 1'b0;
         r_first      <= 1'b0;
         r_zero_done  <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         r_inflight  <= w_issue;
         r_zero_done <= 1'b0;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_beat_left <= r_beat_left - 1'b1;
            r_first     <= 1'b0;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr_ctr   <= cmd_addr;
                  r_issue_left <= cmd_len;
                  r_beat_left  <= cmd_len;
                  r_first      <= 1'b1;
                  if (cmd_len == '0) begin
                     r_zero_done <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_issue) begin
                  r_addr_ctr   <= r_addr_ctr + 1'b1;
                  r_issue_left <= r_issue_left - 1'b1;
                  if (r_issue_left == LEN_WIDTH'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_last_pop) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_stream_reader
// Description : Scoreboard bench for onchip_mem_stream_reader with a RAM model.
// Revision    : 1.0
// ============================================================================
module tb_onchip_mem_stream_reader;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LW = 17;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect;
   logic          mem_write;
   logic [3:0]    mem_byteenable;
   logic          mem_clken;
   logic [DW-1:0] mem_readdata;
   logic          src_valid;
   logic          src_ready = 1'b0;
   logic [DW-1:0] src_data;
   logic          src_sop;
   logic          src_eop;
   logic          busy;
   logic          done;

   onchip_mem_stream_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .src_sop(src_sop), .src_eop(src_eop), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      int            cyc;
   } beat_t;

   beat_t         exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   int            exp_done_q[$];

   logic [DW-1:0] mem_model [0:65535];
   logic [AW-1:0] ram_addr_q = '0;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   int            ready_mode = 0;
   int            first_iss = -1;
   int            last_iss = -1;
   int            outstanding = 0;
   logic          stalled_prev = 1'b0;
   logic [DW-1:0] held_data;
   logic          held_sop, held_eop;
   logic          mon_pop;

   // RAM port model: address registered, read data combinational from it.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_chipselect && mem_clken) ram_addr_q <= mem_address;
   end
   assign mem_readdata = mem_model[ram_addr_q];

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       src_ready = 1'b1;
         1:       src_ready = (cyc % 3 == 0);
         default: src_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: checks issues, beats, stall stability and done against the queues.
   always @(negedge clk) begin
      if (reset) begin
         stalled_prev = 1'b0;
         outstanding  = 0;
      end else begin
         if (busy) chk("fifo_credit", 64'(outstanding <= FD), 64'd1);
         if (mem_chipselect) begin
            chk("mem_write", 64'(mem_write), 64'd0);
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
            if (exp_addr_q.size() == 0) chk("unexpected_issue", 64'd1, 64'd0);
            else chk("issue_addr", 64'(mem_address), 64'(exp_addr_q.pop_front()));
         end
         if (stalled_prev) begin
            chk("stall_valid", 64'(src_valid), 64'd1);
            chk("stall_data", 64'(src_data), 64'(held_data));
            chk("stall_sop", 64'(src_sop), 64'(held_sop));
            chk("stall_eop", 64'(src_eop), 64'(held_eop));
         end
         mon_pop = src_valid && src_ready;
         if (mon_pop) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
            else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_data", 64'(src_data), 64'(b.data));
               chk("beat_sop", 64'(src_sop), 64'(b.sop));
               chk("beat_eop", 64'(src_eop), 64'(b.eop));
               if (b.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(b.cyc));
               if (b.eop) chk("done_on_eop", 64'(done), 64'd1);
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
               int dc;
               dc = exp_done_q.pop_front();
               if (dc >= 0) chk("done_cycle", 64'(cyc), 64'(dc));
            end
         end
         outstanding = outstanding + (mem_chipselect ? 1 : 0) - (mon_pop ? 1 : 0);
         stalled_prev = src_valid && !src_ready;
         held_data = src_data;
         held_sop  = src_sop;
         held_eop  = src_eop;
      end
   end

   task automatic issue_cmd(input logic [AW-1:0] addr, input int len, input bit timed);
      int c;
      logic [AW-1:0] a;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = LW'(len);
      c = cyc;
      for (int i = 0; i < len; i++) begin
         a = addr + AW'(i);
         exp_addr_q.push_back(a);
         exp_q.push_back('{mem_model[a], (i == 0), (i == len - 1), timed ? c + 3 + i : -1});
      end
      exp_done_q.push_back(len == 0 ? c + 1 : (timed ? c + 2 + len : -1));
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("cmd_ready_after", 64'(cmd_ready), (len == 0) ? 64'd1 : 64'd0);
      chk("busy_after", 64'(busy), (len == 0) ? 64'd0 : 64'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!busy && exp_q.size() == 0 && exp_done_q.size() == 0 && exp_addr_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("timeout", 64'd1, 64'd0);
         exp_q.delete();
         exp_addr_q.delete();
         exp_done_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem_model[i] = 32'h5A00_0000 ^ 32'(i * 7);
      for (int i = 0; i < 4; i++) mem_model[16 + i] = 32'hA0 + 32'(i);
      reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #3;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_src_valid", 64'(src_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_chipselect", 64'(mem_chipselect), 64'd0);
      chk("rst_address", 64'(mem_address), 64'd0);
      chk("rst_sop_eop", {62'd0, src_sop, src_eop}, 64'd0);

      // Basic 4-word read with constant ready: exact latency checked.
      issue_cmd(16'h0010, 4, 1'b1);
      wait_idle();

      // Backpressure: ready 1,0,0 repeating.
      ready_mode = 1;
      issue_cmd(16'h0010, 4, 1'b0);
      wait_idle();
      first_iss = -1;
      issue_cmd(16'h0020, 12, 1'b0);
      wait_idle();
      chk("issue_stalled", 64'((last_iss - first_iss) > 11), 64'd1);
      ready_mode = 0;

      // Address wrap.
      issue_cmd(16'hFFFE, 4, 1'b1);
      wait_idle();

      // Zero length and single word.
      issue_cmd(16'h0030, 0, 1'b1);
      wait_idle();
      issue_cmd(16'h0040, 1, 1'b1);
      wait_idle();

      // Reset mid-run with two beats buffered.
      ready_mode = 2;
      issue_cmd(16'h0100, 16, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_reset_valid", 64'(src_valid), 64'd1);
      reset = 1'b1;
      exp_q.delete();
      exp_addr_q.delete();
      exp_done_q.delete();
      #3;
      chk("reset_cycle_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      ready_mode = 0;
      #3;
      chk("post_reset_valid", 64'(src_valid), 64'd0);
      chk("post_reset_busy", 64'(busy), 64'd0);
      chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("post_reset_done", 64'(done), 64'd0);
      issue_cmd(16'h0012, 3, 1'b1);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      chk("beats_left", 64'(exp_q.size()), 64'd0);
      chk("issues_left", 64'(exp_addr_q.size()), 64'd0);
      chk("dones_left", 64'(exp_done_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
